// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_ctrl.sv
// Glitch-free programmable clock divider: CLKO toggles every div_q+1 CLK cycles; new divisors
// are applied only at a high->low boundary, and EN drops never truncate a high phase.
module gf180mcu_osu_sc_gp9t3v3__clkdiv_ctrl #(
  parameter int DW      = 4,
  parameter int RST_DIV = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] DIV,
  input  logic          REQ,
  output logic          ACK,
  output logic          BUSY,
  output logic          CLKO
);

  typedef enum logic [1:0] {S_OFF = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          clko_q, clko_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;

  logic tc, fall, stop_low, off_next, req_cap;

  assign tc       = (cnt_q == div_q);
  assign fall     = (state_q != S_OFF) && clko_q && tc;
  assign stop_low = (state_q == S_RUN) && !EN && !clko_q;
  assign off_next = (state_q != S_OFF) && (state_d == S_OFF);
  assign req_cap  = REQ && !busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      div_q   <= DW'(RST_DIV);
      pend_q  <= '0;
      clko_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      clko_q  <= clko_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:   if (EN) state_d = S_RUN;
      S_RUN:   if (!EN) state_d = (clko_q && !tc) ? S_STOP : S_OFF;
      S_STOP:  state_d = EN ? S_RUN : (tc ? S_OFF : S_STOP);
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    clko_d = clko_q;
    div_d  = div_q;
    pend_d = pend_q;
    busy_d = busy_q;
    ack_d  = 1'b0;
    if (state_q == S_OFF) begin
      cnt_d  = '0;
      clko_d = 1'b0;
      if (REQ) begin
        div_d = DIV;
        ack_d = 1'b1;
      end
    end else begin
      if (stop_low) begin
        cnt_d = '0;
      end else if (tc) begin
        cnt_d  = '0;
        clko_d = !clko_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // Entering OFF is also a safe boundary, so a load is never left stranded behind a stopped clock.
      if (busy_q && (fall || off_next)) begin
        div_d  = pend_q;
        busy_d = 1'b0;
        ack_d  = 1'b1;
      end else if (req_cap && off_next) begin
        div_d = DIV;
        ack_d = 1'b1;
      end else if (req_cap) begin
        pend_d = DIV;
        busy_d = 1'b1;
      end
    end
  end

  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign CLKO = clko_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_ctrl.sv
// Bench for the clock divider: directed scenarios then random traffic, each cycle compared
// against a phase-length model (level + cycles spent in the current phase).
module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_ctrl;

  localparam int DW      = 4;
  localparam int RST_DIV = 1;

  logic          CLK = 1'b0;
  logic          RST, EN, REQ;
  logic [DW-1:0] DIV;
  logic          ACK, BUSY, CLKO;

  gf180mcu_osu_sc_gp9t3v3__clkdiv_ctrl #(.DW(DW), .RST_DIV(RST_DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .DIV (DIV),
    .REQ (REQ),
    .ACK (ACK),
    .BUSY(BUSY),
    .CLKO(CLKO)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit m_on, m_lvl, m_busy, m_ack;
  int m_age, m_div, m_pend;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit en, input bit req, input int dv);
    bit endp, falling, goes_off;
    int phase_len;
    if (rst) begin
      m_on = 0; m_lvl = 0; m_age = 0; m_div = RST_DIV; m_pend = 0; m_busy = 0; m_ack = 0;
      return;
    end
    m_ack = 0;
    if (!m_on) begin
      if (req) begin m_div = dv; m_ack = 1; end
      if (en) begin m_on = 1; m_lvl = 0; m_age = 0; end
      return;
    end
    phase_len = m_div + 1;
    endp      = (m_age + 1 == phase_len);
    falling   = m_lvl && endp;
    goes_off  = !en && (!m_lvl || endp);
    if (m_busy && (falling || goes_off)) begin
      m_div = m_pend; m_busy = 0; m_ack = 1;
    end else if (req && !m_busy && goes_off) begin
      m_div = dv; m_ack = 1;
    end else if (req && !m_busy) begin
      m_pend = dv; m_busy = 1;
    end
    if (!en && !m_lvl) begin
      m_on = 0; m_age = 0;
    end else if (endp) begin
      m_lvl = !m_lvl; m_age = 0;
      if (goes_off) m_on = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit req, input int dv);
    RST = rst; EN = en; REQ = req; DIV = DW'(dv);
    @(posedge CLK);
    model_step(rst, en, req, dv);
    #1;
    chk("clko", int'(CLKO), int'(m_lvl));
    chk("ack",  int'(ACK),  int'(m_ack));
    chk("busy", int'(BUSY), int'(m_busy));
  endtask

  task automatic run_until_rise(input string tag);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      cyc(0, 1, 0, 0);
      if (m_on && m_lvl && m_age == 0) found = 1;
    end
    chk(tag, int'(found), 1);
  endtask

  task automatic run_until_off(input string tag);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (!m_on) found = 1;
    end
    chk(tag, int'(found), 1);
  endtask

  initial begin
    bit en_r;
    RST = 1'b1; EN = 1'b0; REQ = 1'b0; DIV = '0;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_clko", int'(CLKO), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ack",  int'(ACK),  0);

    // Default divisor: first rise two cycles after RUN entry, period 4
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("first_rise_pre", int'(CLKO), 0);
    cyc(0, 1, 0, 0);
    chk("first_rise", int'(CLKO), 1);
    cyc(0, 1, 0, 0);
    chk("div1_high2", int'(CLKO), 1);
    cyc(0, 1, 0, 0);
    chk("div1_fall", int'(CLKO), 0);
    repeat (8) cyc(0, 1, 0, 0);

    // Load from OFF, then period 8
    run_until_off("wait_off_a");
    cyc(0, 0, 1, 3);
    chk("off_load_ack", int'(ACK), 1);
    cyc(0, 0, 0, 0);
    chk("off_ack_pulse", int'(ACK), 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    chk("div3_low4", int'(CLKO), 0);
    cyc(0, 1, 0, 0);
    chk("div3_rise", int'(CLKO), 1);
    repeat (16) cyc(0, 1, 0, 0);

    // Mid-high-phase load with a second request ignored while busy
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    run_until_rise("wait_rise_b");
    cyc(0, 1, 1, 4);
    chk("busy_set", int'(BUSY), 1);
    cyc(0, 1, 1, 7);
    repeat (30) cyc(0, 1, 0, 0);

    // EN drop one cycle after rise with div 2: high phase completes at 3 cycles
    run_until_off("wait_off_c");
    cyc(0, 0, 1, 2);
    cyc(0, 1, 0, 0);
    run_until_rise("wait_rise_c");
    cyc(0, 0, 0, 0);
    chk("stop_hi1", int'(CLKO), 1);
    cyc(0, 0, 0, 0);
    chk("stop_hi2", int'(CLKO), 1);
    cyc(0, 0, 0, 0);
    chk("stop_fall", int'(CLKO), 0);
    repeat (4) cyc(0, 0, 0, 0);

    // EN drop and return inside one high phase
    cyc(0, 1, 0, 0);
    run_until_rise("wait_rise_d");
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (20) cyc(0, 1, 0, 0);

    // Reset while a load is pending in the high phase
    run_until_rise("wait_rise_e");
    cyc(0, 1, 1, 5);
    chk("pend_busy", int'(BUSY), 1);
    cyc(1, 1, 0, 0);
    chk("rst_mid_clko", int'(CLKO), 0);
    chk("rst_mid_busy", int'(BUSY), 0);
    chk("rst_mid_ack",  int'(ACK),  0);
    cyc(0, 0, 0, 0);
    chk("rst_mid_noack", int'(ACK), 0);
    cyc(0, 1, 0, 0);
    run_until_rise("wait_rise_f");

    // Random traffic
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) en_r = !en_r;
      cyc(($urandom_range(499) == 0), en_r, ($urandom_range(7) == 0), int'($urandom_range(15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
